// File: rtl/core_switch_ctrl_pkg.sv
// Shared definitions for the core switchover controller: state encodings,
// default timing parameters and a saturating counter helper.
package core_switch_ctrl_pkg;

   // Default timing: 14.7456 MHz oscillator, 1 ms granularity
   localparam int MS_TICKS_DEF   = 14746;
   localparam int STARTUP_MS_DEF = 200;
   localparam int GUARD_MS_DEF   = 5;

   // Encoding is visible on the debug state output, so keep values fixed
   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_A_ACT  = 3'd1,
      ST_B_ACT  = 3'd2,
      ST_SWITCH = 3'd3,
      ST_NONE   = 3'd4
   } state_t;

   // 8-bit increment that sticks at 255 instead of wrapping
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/core_switch_ctrl_if.sv
// Bundle of heartbeat inputs, manual request and owner-select outputs.
// master = the environment (detectors, mux), slave = the controller.
interface core_switch_ctrl_if;
   logic       alive_a;
   logic       alive_b;
   logic       manual_req;
   logic       manual_sel;
   logic       sel_b;
   logic       active_valid;
   logic       switch_pulse;
   logic [7:0] switch_cnt;
   logic [2:0] state;

   modport master (
      output alive_a, alive_b, manual_req, manual_sel,
      input  sel_b, active_valid, switch_pulse, switch_cnt, state
   );

   modport slave (
      input  alive_a, alive_b, manual_req, manual_sel,
      output sel_b, active_valid, switch_pulse, switch_cnt, state
   );
endinterface

// File: rtl/core_switch_ctrl_ms_tick_gen.sv
// Millisecond prescaler: counts 0..MS_TICKS-1 and flags the last count as
// ms_tick. A synchronous clear restarts the window so timed states always
// begin on a full millisecond.
module ms_tick_gen
   import core_switch_ctrl_pkg::*;
#(
   parameter int MS_TICKS = MS_TICKS_DEF
)(
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   output logic ms_tick_o
);
   localparam int          CW   = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
   localparam logic [CW-1:0] LAST = CW'(MS_TICKS - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins, otherwise wrap at the last tick of the window
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || (cnt_q == LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Prescaler register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Tick is a plain decode; consumers must not feed it back into clr_i
   // combinationally through a gate on the tick itself.
   assign ms_tick_o = (cnt_q == LAST);

endmodule

// File: rtl/core_switch_ctrl.sv
// Core A/B ownership controller. Waits for the heartbeat detectors to
// settle, picks an owner, and moves ownership only on owner failure or a
// valid manual request. Every ownership change passes through a muted
// guard window. Ownership is sticky: a recovering non-owner never takes
// over on its own.
module core_switch_ctrl
   import core_switch_ctrl_pkg::*;
#(
   parameter int MS_TICKS   = MS_TICKS_DEF,
   parameter int STARTUP_MS = STARTUP_MS_DEF,
   parameter int GUARD_MS   = GUARD_MS_DEF
)(
   input  logic              clk,
   input  logic              rst,
   core_switch_ctrl_if.slave ctrl_if
);
   localparam int SCW = $clog2(STARTUP_MS + 1);
   localparam int GCW = $clog2(GUARD_MS + 1);
   localparam logic [SCW-1:0] STARTUP_LAST = SCW'(STARTUP_MS - 1);
   localparam logic [GCW-1:0] GUARD_LAST   = GCW'(GUARD_MS - 1);

   state_t         state_q, state_d;
   logic           sel_b_q, sel_b_d;
   logic           active_valid_q, active_valid_d;
   logic           switch_pulse_q, switch_pulse_d;
   logic [7:0]     switch_cnt_q, switch_cnt_d;
   logic [SCW-1:0] startup_cnt_q, startup_cnt_d;
   logic [GCW-1:0] guard_cnt_q, guard_cnt_d;

   logic ms_tick;
   logic enter_sw;
   logic go_req;
   logic go_tgt;
   logic alive_tgt;
   logic alive_oth;

   ms_tick_gen #(
      .MS_TICKS (MS_TICKS)
   ) u_ms_tick_gen (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (enter_sw),
      .ms_tick_o (ms_tick)
   );

   // Next-state logic: per-state rules raise go_req/go_tgt, then a single
   // resolver decides between a direct hand-off and a guarded switchover.
   always_comb begin
      state_d        = state_q;
      sel_b_d        = sel_b_q;
      switch_pulse_d = 1'b0;
      switch_cnt_d   = switch_cnt_q;
      startup_cnt_d  = startup_cnt_q;
      guard_cnt_d    = guard_cnt_q;
      enter_sw       = 1'b0;
      go_req         = 1'b0;
      go_tgt         = sel_b_q;
      alive_tgt      = sel_b_q ? ctrl_if.alive_b : ctrl_if.alive_a;
      alive_oth      = sel_b_q ? ctrl_if.alive_a : ctrl_if.alive_b;

      case (state_q)
         ST_INIT: begin
            if (ms_tick) begin
               if (startup_cnt_q == STARTUP_LAST) begin
                  if (ctrl_if.alive_a) begin
                     state_d = ST_A_ACT;
                  end else if (ctrl_if.alive_b) begin
                     go_req = 1'b1;
                     go_tgt = 1'b1;
                  end else begin
                     state_d = ST_NONE;
                  end
               end else begin
                  startup_cnt_d = startup_cnt_q + 1'b1;
               end
            end
         end

         ST_A_ACT: begin
            // Owner failure is evaluated first so it overrides a manual request
            if (!ctrl_if.alive_a) begin
               if (ctrl_if.alive_b) begin
                  go_req = 1'b1;
                  go_tgt = 1'b1;
               end else begin
                  state_d = ST_NONE;
               end
            end else if (ctrl_if.manual_req && ctrl_if.manual_sel && ctrl_if.alive_b) begin
               go_req = 1'b1;
               go_tgt = 1'b1;
            end
         end

         ST_B_ACT: begin
            if (!ctrl_if.alive_b) begin
               if (ctrl_if.alive_a) begin
                  go_req = 1'b1;
                  go_tgt = 1'b0;
               end else begin
                  state_d = ST_NONE;
               end
            end else if (ctrl_if.manual_req && !ctrl_if.manual_sel && ctrl_if.alive_a) begin
               go_req = 1'b1;
               go_tgt = 1'b0;
            end
         end

         ST_SWITCH: begin
            if (ms_tick) begin
               if (guard_cnt_q == GUARD_LAST) begin
                  if (alive_tgt) begin
                     state_d = sel_b_q ? ST_B_ACT : ST_A_ACT;
                  end else if (alive_oth) begin
                     go_req = 1'b1;
                     go_tgt = ~sel_b_q;
                  end else begin
                     state_d = ST_NONE;
                  end
               end else begin
                  guard_cnt_d = guard_cnt_q + 1'b1;
               end
            end
         end

         ST_NONE: begin
            // A is preferred when both come back in the same cycle
            if (ctrl_if.alive_a) begin
               go_req = 1'b1;
               go_tgt = 1'b0;
            end else if (ctrl_if.alive_b) begin
               go_req = 1'b1;
               go_tgt = 1'b1;
            end
         end

         default: begin
            state_d = ST_INIT;
         end
      endcase

      // Hand-off resolver: same owner needs no mute window
      if (go_req) begin
         if (go_tgt == sel_b_q) begin
            state_d = go_tgt ? ST_B_ACT : ST_A_ACT;
         end else begin
            state_d        = ST_SWITCH;
            sel_b_d        = go_tgt;
            switch_pulse_d = 1'b1;
            switch_cnt_d   = sat_inc8(switch_cnt_q);
            guard_cnt_d    = '0;
            enter_sw       = 1'b1;
         end
      end

      active_valid_d = (state_d == ST_A_ACT) || (state_d == ST_B_ACT);
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_INIT;
         sel_b_q        <= 1'b0;
         active_valid_q <= 1'b0;
         switch_pulse_q <= 1'b0;
         switch_cnt_q   <= 8'd0;
         startup_cnt_q  <= '0;
         guard_cnt_q    <= '0;
      end else begin
         state_q        <= state_d;
         sel_b_q        <= sel_b_d;
         active_valid_q <= active_valid_d;
         switch_pulse_q <= switch_pulse_d;
         switch_cnt_q   <= switch_cnt_d;
         startup_cnt_q  <= startup_cnt_d;
         guard_cnt_q    <= guard_cnt_d;
      end
   end

   assign ctrl_if.sel_b        = sel_b_q;
   assign ctrl_if.active_valid = active_valid_q;
   assign ctrl_if.switch_pulse = switch_pulse_q;
   assign ctrl_if.switch_cnt   = switch_cnt_q;
   assign ctrl_if.state        = state_q;

endmodule

// File: tb/tb_core_switch_ctrl.sv
// Bench for core_switch_ctrl with short timing (10 clk/ms, 4 ms startup,
// 2 ms guard). A cycle-countdown reference model is compared every cycle;
// directed steps add literal expectations for the key scenarios.
module tb_core_switch_ctrl;
   localparam int MS_T      = 10;
   localparam int ST_MS     = 4;
   localparam int GD_MS     = 2;
   localparam int INIT_CYC  = MS_T * ST_MS;
   localparam int GUARD_CYC = MS_T * GD_MS;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   core_switch_ctrl_if bus();

   core_switch_ctrl #(
      .MS_TICKS   (MS_T),
      .STARTUP_MS (ST_MS),
      .GUARD_MS   (GD_MS)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .ctrl_if (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // States: 0 INIT, 1 A owns, 2 B owns, 3 muted switchover, 4 nobody.
   // Timed states count remaining clock cycles directly.
   logic [2:0] m_state, n_state;
   logic       m_sel, n_sel, m_pulse, n_pulse;
   logic [7:0] m_cnt, n_cnt;
   int         m_left, n_left;
   logic       go_req, go_tgt;

   always_comb begin
      n_state = m_state;
      n_sel   = m_sel;
      n_cnt   = m_cnt;
      n_pulse = 1'b0;
      n_left  = (m_left > 1) ? m_left - 1 : m_left;
      go_req  = 1'b0;
      go_tgt  = 1'b0;
      case (m_state)
         3'd0: if (m_left <= 1) begin
            if (bus.alive_a) n_state = 3'd1;
            else if (bus.alive_b) begin go_req = 1'b1; go_tgt = 1'b1; end
            else n_state = 3'd4;
         end
         3'd1: if (!bus.alive_a) begin
            if (bus.alive_b) begin go_req = 1'b1; go_tgt = 1'b1; end
            else n_state = 3'd4;
         end else if (bus.manual_req && bus.manual_sel && bus.alive_b) begin
            go_req = 1'b1; go_tgt = 1'b1;
         end
         3'd2: if (!bus.alive_b) begin
            if (bus.alive_a) begin go_req = 1'b1; go_tgt = 1'b0; end
            else n_state = 3'd4;
         end else if (bus.manual_req && !bus.manual_sel && bus.alive_a) begin
            go_req = 1'b1; go_tgt = 1'b0;
         end
         3'd3: if (m_left <= 1) begin
            if (m_sel ? bus.alive_b : bus.alive_a) n_state = m_sel ? 3'd2 : 3'd1;
            else if (m_sel ? bus.alive_a : bus.alive_b) begin go_req = 1'b1; go_tgt = ~m_sel; end
            else n_state = 3'd4;
         end
         default: if (bus.alive_a) begin go_req = 1'b1; go_tgt = 1'b0; end
                  else if (bus.alive_b) begin go_req = 1'b1; go_tgt = 1'b1; end
      endcase
      if (go_req) begin
         if (go_tgt == m_sel) begin
            n_state = go_tgt ? 3'd2 : 3'd1;
         end else begin
            n_state = 3'd3;
            n_sel   = go_tgt;
            n_pulse = 1'b1;
            n_cnt   = (m_cnt == 8'd255) ? 8'd255 : m_cnt + 8'd1;
            n_left  = GUARD_CYC;
         end
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_state <= 3'd0;
         m_sel   <= 1'b0;
         m_cnt   <= 8'd0;
         m_pulse <= 1'b0;
         m_left  <= INIT_CYC;
      end else begin
         m_state <= n_state;
         m_sel   <= n_sel;
         m_cnt   <= n_cnt;
         m_pulse <= n_pulse;
         m_left  <= n_left;
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      check("cmp_state", 32'(bus.state), 32'(m_state));
      check("cmp_sel_b", 32'(bus.sel_b), 32'(m_sel));
      check("cmp_valid", 32'(bus.active_valid), 32'(m_state == 3'd1 || m_state == 3'd2));
      check("cmp_pulse", 32'(bus.switch_pulse), 32'(m_pulse));
      check("cmp_cnt",   32'(bus.switch_cnt), 32'(m_cnt));
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Observations spent in state 'from', starting with the current one
   task automatic dwell(input logic [2:0] from, output int n);
      n = 0;
      while (bus.state == from && n < 200) begin
         n++;
         step();
      end
      if (n >= 200) check("dwell_timeout", 32'(n), 32'd0);
   endtask

   task automatic manual(input logic sel);
      bus.manual_req = 1'b1;
      bus.manual_sel = sel;
      step();
      bus.manual_req = 1'b0;
   endtask

   int n;
   int pulses;

   initial begin
      rst            = 1'b1;
      bus.alive_a    = 1'b1;
      bus.alive_b    = 1'b1;
      bus.manual_req = 1'b0;
      bus.manual_sel = 1'b0;
      repeat (3) step();
      rst = 1'b0;

      // Startup with both alive
      dwell(3'd0, n);
      $display("txn startup: INIT held %0d cycles, state=%0d", n, bus.state);
      check("init_len", 32'(n), 32'd40);
      check("init_state", 32'(bus.state), 32'd1);
      check("init_sel", 32'(bus.sel_b), 32'd0);
      check("init_valid", 32'(bus.active_valid), 32'd1);
      check("init_cnt", 32'(bus.switch_cnt), 32'd0);

      // Owner A fails -> guarded switch to B
      bus.alive_a = 1'b0;
      step();
      $display("txn fail_a: state=%0d sel_b=%0d cnt=%0d", bus.state, bus.sel_b, bus.switch_cnt);
      check("fa_state", 32'(bus.state), 32'd3);
      check("fa_sel", 32'(bus.sel_b), 32'd1);
      check("fa_pulse", 32'(bus.switch_pulse), 32'd1);
      check("fa_cnt", 32'(bus.switch_cnt), 32'd1);
      check("fa_valid", 32'(bus.active_valid), 32'd0);
      dwell(3'd3, n);
      check("guard_len", 32'(n), 32'd20);
      check("fa_b_act", 32'(bus.state), 32'd2);
      bus.alive_a = 1'b1;
      repeat (5) step();
      $display("txn recover_a: state=%0d", bus.state);
      check("sticky", 32'(bus.state), 32'd2);

      // Both fail, then both return together
      bus.alive_a = 1'b0;
      bus.alive_b = 1'b0;
      step();
      $display("txn both_dead: state=%0d sel_b=%0d", bus.state, bus.sel_b);
      check("none_state", 32'(bus.state), 32'd4);
      check("none_sel", 32'(bus.sel_b), 32'd1);
      bus.alive_a = 1'b1;
      bus.alive_b = 1'b1;
      step();
      check("both_back_state", 32'(bus.state), 32'd3);
      check("both_back_sel", 32'(bus.sel_b), 32'd0);
      dwell(3'd3, n);
      $display("txn both_back: state=%0d cnt=%0d", bus.state, bus.switch_cnt);
      check("both_back_a", 32'(bus.state), 32'd1);
      check("both_back_cnt", 32'(bus.switch_cnt), 32'd2);

      // Manual to B, then manual to dead A ignored, then honoured
      manual(1'b1);
      check("man_b_sel", 32'(bus.sel_b), 32'd1);
      dwell(3'd3, n);
      bus.alive_a = 1'b0;
      manual(1'b0);
      $display("txn manual_dead_a: state=%0d", bus.state);
      check("man_dead_ignored", 32'(bus.state), 32'd2);
      bus.alive_a = 1'b1;
      step();
      manual(1'b0);
      $display("txn manual_a: state=%0d sel_b=%0d cnt=%0d", bus.state, bus.sel_b, bus.switch_cnt);
      check("man_a_state", 32'(bus.state), 32'd3);
      check("man_a_sel", 32'(bus.sel_b), 32'd0);
      check("man_a_cnt", 32'(bus.switch_cnt), 32'd4);
      dwell(3'd3, n);
      manual(1'b1);
      dwell(3'd3, n);
      // Failure and manual in the same cycle: one switch only
      bus.alive_b = 1'b0;
      manual(1'b0);
      $display("txn fail_plus_manual: state=%0d sel_b=%0d cnt=%0d", bus.state, bus.sel_b, bus.switch_cnt);
      check("fm_state", 32'(bus.state), 32'd3);
      check("fm_cnt", 32'(bus.switch_cnt), 32'd6);
      dwell(3'd3, n);
      check("fm_a_act", 32'(bus.state), 32'd1);
      bus.alive_b = 1'b1;
      step();

      // 260 manual switchovers: counter saturates, pulses continue
      pulses = 0;
      for (int i = 0; i < 260; i++) begin
         manual(~bus.sel_b);
         if (bus.switch_pulse === 1'b1) pulses++;
         dwell(3'd3, n);
      end
      $display("txn manual_x260: pulses=%0d cnt=%0d", pulses, bus.switch_cnt);
      check("sat_pulses", 32'(pulses), 32'd260);
      check("sat_cnt", 32'(bus.switch_cnt), 32'd255);

      // Asynchronous reset in the middle of a switchover toward B
      if (bus.sel_b) begin
         manual(1'b0);
         dwell(3'd3, n);
      end
      manual(1'b1);
      repeat (5) step();
      check("pre_rst_state", 32'(bus.state), 32'd3);
      #1 rst = 1'b1;
      #1;
      $display("txn async_rst: state=%0d sel_b=%0d cnt=%0d", bus.state, bus.sel_b, bus.switch_cnt);
      check("ar_state", 32'(bus.state), 32'd0);
      check("ar_sel", 32'(bus.sel_b), 32'd0);
      check("ar_valid", 32'(bus.active_valid), 32'd0);
      check("ar_pulse", 32'(bus.switch_pulse), 32'd0);
      check("ar_cnt", 32'(bus.switch_cnt), 32'd0);
      bus.alive_a = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      // Only B alive at the end of startup -> guarded switch to B
      dwell(3'd0, n);
      $display("txn startup_b: INIT held %0d cycles, state=%0d", n, bus.state);
      check("init2_len", 32'(n), 32'd40);
      check("init2_state", 32'(bus.state), 32'd3);
      check("init2_sel", 32'(bus.sel_b), 32'd1);
      check("init2_cnt", 32'(bus.switch_cnt), 32'd1);

      // Randomized traffic checked against the model every cycle
      bus.alive_a = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) bus.alive_a = ~bus.alive_a;
         if ($urandom_range(0, 49) == 0) bus.alive_b = ~bus.alive_b;
         bus.manual_req = ($urandom_range(0, 14) == 0);
         bus.manual_sel = 1'($urandom_range(0, 1));
         rst = (i == 1500);
         step();
      end
      rst            = 1'b0;
      bus.manual_req = 1'b0;
      step();
      $display("txn random: 3000 cycles done, state=%0d cnt=%0d", bus.state, bus.switch_cnt);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
